// File: rtl/hazard_pkg.sv
// Shared types and encodings for the decode->execute hazard/forwarding controller.
package hazard_pkg;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_ALU = 2'b01;
  localparam logic [1:0] SEL_ALT = 2'b11;

  localparam logic [3:0] PC_REG = 4'd15;

  typedef enum logic [1:0] {RUN, LD_WAIT, FLUSH} state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] w_addr;
    logic       w_en;
    logic       is_load;
    logic       sets_flags;
  } sb_rec_t;

  // r15 is the PC: it is never tracked as a data dependency.
  function automatic logic reg_hit(logic [3:0] src, sb_rec_t rec);
    return rec.valid && rec.w_en && (src == rec.w_addr) && (src != PC_REG);
  endfunction

endpackage

// File: rtl/hazard_if.sv
// Decode-side bundle of the hazard controller: instruction fields in, mux selects and pipeline controls out.
interface hazard_if;
  logic       dec_valid;
  logic [3:0] dec_A_addr;
  logic [3:0] dec_B_addr;
  logic [3:0] dec_shift_addr;
  logic [3:0] dec_str_addr;
  logic [3:0] dec_use;
  logic       dec_A_pc;
  logic       dec_B_imm;
  logic       dec_shift_imm;
  logic [3:0] dec_w_addr;
  logic       dec_w_en;
  logic       dec_is_load;
  logic       dec_sets_flags;
  logic       dec_reads_flags;
  logic       ex_branch_taken;
  logic [1:0] sel_A_in;
  logic [1:0] sel_B_in;
  logic [1:0] sel_shift_in;
  logic       en_A;
  logic       en_B;
  logic       en_S;
  logic       stall_fd;
  logic       bubble;
  logic       flush;

  modport master (
    output dec_valid, dec_A_addr, dec_B_addr, dec_shift_addr, dec_str_addr, dec_use,
           dec_A_pc, dec_B_imm, dec_shift_imm, dec_w_addr, dec_w_en, dec_is_load,
           dec_sets_flags, dec_reads_flags, ex_branch_taken,
    input  sel_A_in, sel_B_in, sel_shift_in, en_A, en_B, en_S, stall_fd, bubble, flush
  );

  modport slave (
    input  dec_valid, dec_A_addr, dec_B_addr, dec_shift_addr, dec_str_addr, dec_use,
           dec_A_pc, dec_B_imm, dec_shift_imm, dec_w_addr, dec_w_en, dec_is_load,
           dec_sets_flags, dec_reads_flags, ex_branch_taken,
    output sel_A_in, sel_B_in, sel_shift_in, en_A, en_B, en_S, stall_fd, bubble, flush
  );
endinterface

// File: rtl/hazard_fwd_sel.sv
// Operand-mux select for one source: alternate operand, ALU bypass from EX, or regfile.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [3:0] src_addr,
  input  logic       used,
  input  logic       alt,
  input  sb_rec_t    ex,
  output logic [1:0] sel
);

  // NOTE: assign a default first so every path drives sel and no latch is inferred.
  always_comb begin
    sel = SEL_RF;
    if (alt)
      sel = SEL_ALT;
    else if (used && !ex.is_load && reg_hit(src_addr, ex))
      sel = SEL_ALU;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller: EX/MEM scoreboard, forwarding selects, stall/bubble/flush FSM.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_LAT     = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int RF_BYPASS    = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  hazard_if.slave  hz
);

  localparam logic [2:0] LD_RELOAD = 3'(LOAD_LAT - 1);
  localparam logic [2:0] FL_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_e     state;
  logic [2:0] cnt;
  sb_rec_t    ex_rec, mem_rec, dec_rec;
  logic [3:0] eff_use;
  logic [1:0] a_sel, b_sel, s_sel;
  logic       ld_hit, flg_hit, str_hit, raw_hit, hazard;
  logic       active, flush_now, ld_wait_now;
  logic       en_ops, stall_c, bubble_c, flush_c;

  fwd_sel u_fwd_a (.src_addr(hz.dec_A_addr),     .used(hz.dec_use[0]), .alt(hz.dec_A_pc),
                   .ex(ex_rec), .sel(a_sel));
  fwd_sel u_fwd_b (.src_addr(hz.dec_B_addr),     .used(hz.dec_use[1]), .alt(hz.dec_B_imm),
                   .ex(ex_rec), .sel(b_sel));
  fwd_sel u_fwd_s (.src_addr(hz.dec_shift_addr), .used(hz.dec_use[2]), .alt(hz.dec_shift_imm),
                   .ex(ex_rec), .sel(s_sel));

  // A source replaced by PC/immediate/zero reads no register and cannot hazard.
  assign eff_use = {hz.dec_use[3],
                    hz.dec_use[2] & ~hz.dec_shift_imm,
                    hz.dec_use[1] & ~hz.dec_B_imm,
                    hz.dec_use[0] & ~hz.dec_A_pc};

  function automatic logic src_hit(sb_rec_t rec);
    return (eff_use[0] && reg_hit(hz.dec_A_addr, rec))
        || (eff_use[1] && reg_hit(hz.dec_B_addr, rec))
        || (eff_use[2] && reg_hit(hz.dec_shift_addr, rec))
        || (eff_use[3] && reg_hit(hz.dec_str_addr, rec));
  endfunction

  assign ld_hit  = (src_hit(ex_rec) && ex_rec.is_load) || (src_hit(mem_rec) && mem_rec.is_load);
  assign flg_hit = hz.dec_reads_flags && ex_rec.valid && ex_rec.sets_flags;
  assign str_hit = eff_use[3] && !ex_rec.is_load && reg_hit(hz.dec_str_addr, ex_rec);
  assign raw_hit = (RF_BYPASS == 0) && src_hit(mem_rec) && !mem_rec.is_load;
  assign hazard  = hz.dec_valid && (ld_hit || flg_hit || str_hit || raw_hit);

  // A wait state whose counter has drained behaves exactly like RUN.
  assign active      = (state != RUN) && (cnt != 3'd0);
  assign flush_now   = hz.ex_branch_taken || (active && state == FLUSH);
  assign ld_wait_now = active && state == LD_WAIT;

  assign dec_rec = '{valid:      hz.dec_valid,
                     w_addr:     hz.dec_w_addr,
                     w_en:       hz.dec_w_en,
                     is_load:    hz.dec_is_load,
                     sets_flags: hz.dec_sets_flags};

  always_comb begin
    en_ops   = 1'b1;
    stall_c  = 1'b0;
    bubble_c = 1'b0;
    flush_c  = 1'b0;
    if (!rst_n) begin
      en_ops = 1'b0;
    end else if (flush_now) begin
      en_ops   = 1'b0;
      bubble_c = 1'b1;
      flush_c  = 1'b1;
    end else if (ld_wait_now || hazard) begin
      en_ops   = 1'b0;
      stall_c  = 1'b1;
      bubble_c = 1'b1;
    end else if (!hz.dec_valid) begin
      bubble_c = 1'b1;
    end
  end

  assign hz.sel_A_in     = rst_n ? a_sel : SEL_RF;
  assign hz.sel_B_in     = rst_n ? b_sel : SEL_RF;
  assign hz.sel_shift_in = rst_n ? s_sel : SEL_RF;
  assign hz.en_A         = en_ops;
  assign hz.en_B         = en_ops;
  assign hz.en_S         = en_ops;
  assign hz.stall_fd     = stall_c;
  assign hz.bubble       = bubble_c;
  assign hz.flush        = flush_c;

  // NOTE: asynchronous reset in the sensitivity list; state updates use non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      cnt     <= 3'd0;
      ex_rec  <= '0;
      mem_rec <= '0;
    end else begin
      mem_rec <= ex_rec;
      ex_rec  <= bubble_c ? sb_rec_t'('0) : dec_rec;
      if (hz.ex_branch_taken) begin
        state <= FLUSH;
        cnt   <= FL_RELOAD;
      end else if (active) begin
        cnt <= cnt - 3'd1;
      end else if (hz.dec_valid && ld_hit) begin
        state <= LD_WAIT;
        cnt   <= LD_RELOAD;
      end else begin
        state <= RUN;
        cnt   <= 3'd0;
      end
    end
  end

endmodule
